// File: rtl/barrel_pkg.sv
// Shared constants and types for the barrel shifter result path.
package barrel_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  function automatic int len_w(input int nibbles);
    return $clog2(nibbles + 1);
  endfunction

  // Packed {word, dirs, len} record width for a given word size.
  function automatic int rec_w(input int nibbles);
    return NIB_W * nibbles + nibbles + $clog2(nibbles + 1);
  endfunction

endpackage

// File: rtl/barrel_word_fifo.sv
// Synchronous word FIFO; head reads as zero while empty.
module barrel_word_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/barrel_result_packer.sv
// Packs shifter result nibbles into NIBBLES-wide words with early flush.
module barrel_result_packer
  import barrel_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIB_W-1:0]            in_result,
  input  logic                        in_dir,
  input  logic                        flush_req,
  output logic                        flush_ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIB_W*NIBBLES-1:0]    out_word,
  output logic [NIBBLES-1:0]          out_dirs,
  output logic [$clog2(NIBBLES+1)-1:0] out_len
);

  localparam int CW = $clog2(NIBBLES);
  localparam int LW = len_w(NIBBLES);
  localparam int RW = rec_w(NIBBLES);

  typedef struct packed {
    logic [NIBBLES-1:0][NIB_W-1:0] word;
    logic [NIBBLES-1:0]            dirs;
    logic [LW-1:0]                 len;
  } rec_t;

  logic [CW-1:0]                 cnt;
  logic [NIBBLES-1:0][NIB_W-1:0] slots, slots_nx;
  logic [NIBBLES-1:0]            dirs, dirs_nx;
  logic [LW-1:0]                 len_nx;
  logic                          full, empty, accept, closes;
  dir_t                          dir_in;
  rec_t                          push_rec, head_rec;

  assign dir_in    = dir_t'(in_dir);
  assign in_ready  = !full;
  assign flush_ack = flush_req && !full;
  assign accept    = in_valid && !full;

  // Next accumulator image includes this cycle's beat so a same-cycle flush captures it.
  always_comb begin
    slots_nx = slots;
    dirs_nx  = dirs;
    for (int i = 0; i < NIBBLES; i++) begin
      if (accept && cnt == CW'(i)) begin
        slots_nx[i] = in_result;
        dirs_nx[i]  = dir_in;
      end
    end
    len_nx = LW'(cnt) + LW'(accept);
  end

  assign closes = (accept && cnt == CW'(NIBBLES - 1)) || (flush_ack && len_nx != '0);

  always_comb begin
    push_rec.word = slots_nx;
    push_rec.dirs = dirs_nx;
    push_rec.len  = len_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      slots <= '0;
      dirs  <= '0;
    end else if (closes) begin
      cnt   <= '0;
      slots <= '0;
      dirs  <= '0;
    end else if (accept) begin
      cnt   <= cnt + CW'(1);
      slots <= slots_nx;
      dirs  <= dirs_nx;
    end
  end

  barrel_word_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (closes),
    .din   (push_rec),
    .pop   (out_valid && out_ready),
    .dout  (head_rec),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_word  = head_rec.word;
  assign out_dirs  = head_rec.dirs;
  assign out_len   = head_rec.len;

endmodule

// File: tb/tb_barrel_result_packer.sv
// Directed table, back-pressure/reset sequences and a scoreboarded random run.
module tb_barrel_result_packer;

  localparam int N = 4;
  localparam int D = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_dir = 1'b0, flush_req = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_result = '0;
  logic        in_ready, flush_ack, out_valid;
  logic [15:0] out_word;
  logic [3:0]  out_dirs;
  logic [2:0]  out_len;

  barrel_result_packer #(.NIBBLES(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dir(in_dir), .flush_req(flush_req),
    .flush_ack(flush_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_dirs(out_dirs), .out_len(out_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] r, input logic d);
    in_valid  = 1'b1;
    in_result = r;
    in_dir    = d;
    step();
    in_valid  = 1'b0;
  endtask

  typedef struct {
    logic v; logic [3:0] r; logic d; logic f; logic ordy;
    logic e_rdy; logic e_ack; logic e_ov; logic [15:0] e_w; logic [3:0] e_d; logic [2:0] e_l;
  } vec_t;

  typedef struct { logic [15:0] w; logic [3:0] d; logic [2:0] l; } exp_t;

  function automatic vec_t mk(input logic v, input logic [3:0] r, input logic d, input logic f,
                              input logic ordy, input logic e_rdy, input logic e_ack,
                              input logic e_ov, input logic [15:0] e_w, input logic [3:0] e_d,
                              input logic [2:0] e_l);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.f = f; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_ack = e_ack; t.e_ov = e_ov; t.e_w = e_w; t.e_d = e_d; t.e_l = e_l;
    return t;
  endfunction

  vec_t tbl[16];
  exp_t q[$];
  logic [15:0] pw;
  logic [3:0]  pd;
  int          pn;

  // Scoreboard step: sampled at negedge, before the edge that commits the handshakes.
  task automatic sb_cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_pop", {9'd0, out_word, out_dirs, out_len}, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_word", {9'd0, out_word, out_dirs, out_len}, {9'd0, e.w, e.d, e.l});
      end
    end
    if (in_valid && in_ready) begin
      pw[pn*4 +: 4] = in_result;
      pd[pn]        = in_dir;
      pn++;
    end
    if (pn == N || (flush_ack && pn != 0)) begin
      e.w = pw; e.d = pd; e.l = 3'(pn);
      q.push_back(e);
      pw = '0; pd = '0; pn = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic rdy;
    tbl[0]  = mk(1, 4'h1, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[1]  = mk(1, 4'h2, 1, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[2]  = mk(1, 4'h3, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[3]  = mk(1, 4'h4, 1, 0, 1, 1, 0, 1, 16'h4321, 4'b1010, 4);
    tbl[4]  = mk(1, 4'hA, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[5]  = mk(1, 4'hB, 1, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[6]  = mk(0, 4'h0, 0, 1, 1, 1, 1, 1, 16'h00BA, 4'b0010, 2);
    tbl[7]  = mk(0, 4'h0, 0, 1, 1, 1, 1, 0, 16'h0000, 4'b0000, 0);
    tbl[8]  = mk(1, 4'h1, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[9]  = mk(1, 4'h2, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[10] = mk(1, 4'h3, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[11] = mk(1, 4'h4, 0, 1, 1, 1, 1, 1, 16'h4321, 4'b0000, 4);
    tbl[12] = mk(0, 4'h0, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);
    tbl[13] = mk(1, 4'h9, 1, 1, 0, 1, 1, 1, 16'h0009, 4'b0001, 1);
    tbl[14] = mk(0, 4'h0, 0, 0, 0, 1, 0, 1, 16'h0009, 4'b0001, 1);
    tbl[15] = mk(0, 4'h0, 0, 0, 1, 1, 0, 0, 16'h0000, 4'b0000, 0);

    #11;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flush_ack", flush_ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_dirs", out_dirs, 0);
    chk("rst_out_len", out_len, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].v; in_result = tbl[i].r; in_dir = tbl[i].d;
      flush_req = tbl[i].f; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_flush_ack", i), flush_ack, tbl[i].e_ack);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_out_word", i), out_word, tbl[i].e_w);
      chk($sformatf("vec%0d_out_dirs", i), out_dirs, tbl[i].e_d);
      chk($sformatf("vec%0d_out_len", i), out_len, tbl[i].e_l);
    end
    in_valid = 0; flush_req = 0;

    // Back-pressure: FIFO fills after two words, flush is refused while full.
    out_ready = 0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1; in_result = 4'(acc + 1); in_dir = acc[0];
      #1;
      rdy = in_ready;
      step();
      if (rdy) acc++;
    end
    chk("bp_accepted", acc, 8);
    chk("bp_in_ready", in_ready, 0);
    flush_req = 1;
    #1;
    chk("bp_flush_ack", flush_ack, 0);
    chk("bp_head0", out_word, 16'h4321);
    in_valid = 0; flush_req = 0; out_ready = 1;
    #1;
    chk("bp_ready_same_cycle_pop", in_ready, 0);
    step();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_head1", out_word, 16'h8765);
    chk("bp_head1_dirs", out_dirs, 4'b1010);
    step();
    chk("bp_drained", out_valid, 0);

    // Asynchronous reset with a queued word and a partial word.
    out_ready = 0;
    beat(4'h1, 0); beat(4'h2, 0); beat(4'h3, 0); beat(4'h4, 0);
    beat(4'h5, 1); beat(4'h6, 1);
    chk("ar_queued", out_valid, 1);
    rst_n = 0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_word", out_word, 0);
    #2 rst_n = 1;
    out_ready = 1;
    beat(4'h5, 0); beat(4'h6, 0); beat(4'h7, 0); beat(4'h8, 0);
    chk("ar_restart_word", out_word, 16'h8765);
    chk("ar_restart_len", out_len, 4);
    chk("ar_restart_dirs", out_dirs, 0);
    step();

    // Random handshake stress against the scoreboard.
    pw = '0; pd = '0; pn = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_result = 4'($urandom_range(15));
      in_dir    = 1'($urandom_range(1));
      flush_req = ($urandom_range(7) == 0);
      out_ready = ($urandom_range(2) != 0);
      sb_cycle();
    end
    in_valid = 0; flush_req = 1; out_ready = 1;
    for (int c = 0; c < 30; c++) sb_cycle();
    flush_req = 0;
    chk("sb_queue_empty", q.size(), 0);
    chk("sb_partial_empty", pn, 0);
    chk("sb_fifo_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
